// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, multiply-sequencer state encoding and iteration count.
// ALU_MUL_RADIX4_EN selects radix-4 stepping (two multiplier bits per BUSY cycle).
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_MUL = 3'b100
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mul_state_e;

`ifdef ALU_MUL_RADIX4_EN
   localparam int unsigned MUL_BITS_PER_ITER = 2;
`else
   localparam int unsigned MUL_BITS_PER_ITER = 1;
`endif

   function automatic int unsigned mul_iter(input int unsigned width);
      return width / MUL_BITS_PER_ITER;
   endfunction

   localparam int unsigned ITER = mul_iter(32);

endpackage

// File: rtl/alu_mul_step.sv
// One shift-add multiply iteration: next accumulator, multiplicand and multiplier.
// ALU_MUL_RADIX4_EN consumes two multiplier bits per step instead of one.
module alu_mul_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0] mplier_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] mcand_o,
   output logic [WIDTH-1:0] mplier_o
);

   logic [WIDTH-1:0] addend;

`ifdef ALU_MUL_RADIX4_EN
   always_comb begin
      addend = '0;
      case (mplier_i[1:0])
         2'd1:    addend = mcand_i;
         2'd2:    addend = mcand_i << 1;
         2'd3:    addend = mcand_i + (mcand_i << 1);
         default: addend = '0;
      endcase
      acc_o    = acc_i + addend;
      mcand_o  = mcand_i << 2;
      mplier_o = mplier_i >> 2;
   end
`else
   always_comb begin
      addend   = mplier_i[0] ? mcand_i : '0;
      acc_o    = acc_i + addend;
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
   end
`endif

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle multiply sequencer beside the EX-stage ALU; stalls the pipeline until done.
// ALU_MUL_RADIX4_EN halves the iteration count via radix-4 steps in alu_mul_step.
module alu_mul_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter logic [2:0]  MUL_CODE = ALU_MUL
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [2:0]       alu_ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned N_ITER = mul_iter(WIDTH);
   localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   mul_state_e       state;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [WIDTH-1:0] acc_nxt, mcand_nxt, mplier_nxt;
   logic [CNT_W-1:0] cnt;
   logic             start;

   assign start   = (state == ST_IDLE) && valid_i && (alu_ctrl_i == MUL_CODE) && !flush_i;
   assign stall_o = start || (state == ST_BUSY);

   alu_mul_step #(.WIDTH(WIDTH)) u_step (
      .acc_i    (acc),
      .mcand_i  (mcand),
      .mplier_i (mplier),
      .acc_o    (acc_nxt),
      .mcand_o  (mcand_nxt),
      .mplier_o (mplier_nxt)
   );

   // done_o and busy_o are set on the edge entering their state, so they track it exactly
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         result_o <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mcand  <= src1_i;
                  mplier <= src2_i;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= ST_BUSY;
                  busy_o <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (flush_i) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand_nxt;
                  mplier <= mplier_nxt;
                  cnt    <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(N_ITER - 1)) begin
                     state    <= ST_DONE;
                     busy_o   <= 1'b0;
                     done_o   <= 1'b1;
                     result_o <= acc_nxt;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: vector table plus flush, reset and back-to-back sequences.
// Expected products come from the bench's own table constants or 32-bit multiplication.
module tb_alu_mul_seq;

`ifdef ALU_MUL_RADIX4_EN
   localparam int unsigned N_ITER = 16;
`else
   localparam int unsigned N_ITER = 32;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [2:0]  alu_ctrl_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   alu_mul_seq #(.WIDTH(32), .MUL_CODE(3'b100)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .alu_ctrl_i (alu_ctrl_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc_ctr = 0;
   always @(posedge clk) cyc_ctr++;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  ctrl;
      logic        valid;
      logic        flush;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t        vec [NV];
   logic [31:0] sb [$];
   logic [31:0] last_res = '0;
   int          nvec = 0;
   int          nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input bit flush_done, output int unsigned start_cyc);
      int unsigned cyc;
      int unsigned stalls;
      logic [31:0] want;
      @(posedge clk); #1;
      start_cyc  = cyc_ctr;
      valid_i    = 1'b1;
      alu_ctrl_i = 3'b100;
      src1_i     = a;
      src2_i     = b;
      flush_i    = 1'b0;
      sb.push_back(exp);
      @(negedge clk);
      chk("stall_start", {31'd0, stall_o}, 32'd1);
      @(posedge clk); #1;
      valid_i    = 1'b0;
      alu_ctrl_i = 3'b000;
      src1_i     = $urandom;
      src2_i     = $urandom;
      cyc    = 0;
      stalls = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (done_o) break;
         if (stall_o) stalls++;
         if (cyc > 200) begin
            chk("done_timeout", {31'd0, done_o}, 32'd1);
            void'(sb.pop_back());
            return;
         end
      end
      chk("latency", cyc, N_ITER + 1);
      chk("stall_cycles", stalls + 1, N_ITER + 1);
      chk("stall_in_done", {31'd0, stall_o}, 32'd0);
      chk("busy_in_done", {31'd0, busy_o}, 32'd0);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         want = sb.pop_front();
         chk("result", result_o, want);
         last_res = want;
      end
      if (flush_done) begin
         flush_i = 1'b1;
         @(posedge clk); #1;
         flush_i = 1'b0;
         @(negedge clk);
         chk("done_after_flush", {31'd0, done_o}, 32'd0);
         chk("busy_after_flush", {31'd0, busy_o}, 32'd0);
         chk("result_after_flush", result_o, last_res);
      end
   endtask

   task automatic apply_nostart(input vec_t v);
      @(posedge clk); #1;
      valid_i    = v.valid;
      alu_ctrl_i = v.ctrl;
      src1_i     = v.a;
      src2_i     = v.b;
      flush_i    = v.flush;
      @(negedge clk);
      chk("nostart_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clk);
      chk("nostart_busy", {31'd0, busy_o}, 32'd0);
      chk("nostart_done", {31'd0, done_o}, 32'd0);
      chk("nostart_result", result_o, last_res);
   endtask

   initial begin
      int unsigned s1, s2, dones;
      logic [31:0] ra, rb;

      vec[0]  = '{32'd3,        32'd5,        3'b100, 1'b1, 1'b0, 32'd15};
      vec[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, 1'b1, 1'b0, 32'h00000001};
      vec[2]  = '{32'h80000000, 32'd2,        3'b100, 1'b1, 1'b0, 32'h00000000};
      vec[3]  = '{32'h12345678, 32'h9,        3'b000, 1'b1, 1'b0, 32'h0};
      vec[4]  = '{32'h0000FFFF, 32'h0000FFFF, 3'b100, 1'b1, 1'b0, 32'hFFFE0001};
      vec[5]  = '{32'hFFFFFFFD, 32'd7,        3'b100, 1'b1, 1'b0, 32'hFFFFFFEB};
      vec[6]  = '{32'd6,        32'd6,        3'b100, 1'b0, 1'b0, 32'h0};
      vec[7]  = '{32'd6,        32'd6,        3'b100, 1'b1, 1'b1, 32'h0};
      vec[8]  = '{32'h12345678, 32'd1,        3'b100, 1'b1, 1'b0, 32'h12345678};
      vec[9]  = '{32'h00010000, 32'h00010000, 3'b100, 1'b1, 1'b0, 32'h00000000};
      vec[10] = '{32'hDEADBEEF, 32'h5,        3'b011, 1'b1, 1'b0, 32'h0};
      vec[11] = '{32'd1000,     32'd1000,     3'b100, 1'b1, 1'b0, 32'd1000000};

      rst_i = 1'b0; valid_i = 1'b0; alu_ctrl_i = 3'b000;
      src1_i = '0; src2_i = '0; flush_i = 1'b0;
      #3;
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (vec[i].valid && vec[i].ctrl == 3'b100 && !vec[i].flush)
            do_mul(vec[i].a, vec[i].b, vec[i].exp, 1'b0, s1);
         else
            apply_nostart(vec[i]);
      end

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         do_mul(ra, rb, ra * rb, (i == 0), s1);
      end

      // flush in BUSY cycle 10 abandons 7x9
      @(posedge clk); #1;
      valid_i = 1'b1; alu_ctrl_i = 3'b100; src1_i = 32'd7; src2_i = 32'd9;
      @(posedge clk); #1;
      valid_i = 1'b0; alu_ctrl_i = 3'b000;
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_busy_after", {31'd0, busy_o}, 32'd0);
      chk("flush_stall_after", {31'd0, stall_o}, 32'd0);
      chk("flush_result_kept", result_o, last_res);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      chk("flush_no_done", dones, 32'd0);
      do_mul(32'd2, 32'd2, 32'd4, 1'b0, s1);

      // async reset in BUSY cycle 5 drops 11x13
      @(posedge clk); #1;
      valid_i = 1'b1; alu_ctrl_i = 3'b100; src1_i = 32'd11; src2_i = 32'd13;
      @(posedge clk); #1;
      valid_i = 1'b0; alu_ctrl_i = 3'b000;
      repeat (4) @(posedge clk);
      #3;
      rst_i = 1'b0;
      #1;
      chk("arst_stall", {31'd0, stall_o}, 32'd0);
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      chk("arst_done", {31'd0, done_o}, 32'd0);
      chk("arst_result", result_o, 32'd0);
      last_res = '0;
      @(negedge clk);
      rst_i = 1'b1;
      do_mul(32'd6, 32'd7, 32'd42, 1'b0, s1);

      // back-to-back: second start in the IDLE cycle right after the first DONE
      do_mul(32'd4, 32'd4, 32'd16, 1'b0, s1);
      do_mul(32'd5, 32'd5, 32'd25, 1'b0, s2);
      chk("b2b_second_start", s2 - s1, N_ITER + 2);
      chk("b2b_total_cycles", cyc_ctr - s1 + 1, 2 * N_ITER + 4);

      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer for the ALU multiply operation (ALU control code `3'b100`) in the 32-bit pipelined CPU. It sits beside the EX-stage ALU and runs an iterative shift-add multiply over several cycles. It holds the pipeline with `stall_o` until the product is ready, then releases it. Only multiply uses this block; every other ALU operation passes through it without any stall.

## Interface
- `WIDTH`, 32, operand and result width.
- `MUL_CODE`, `3'b100`, ALU control code that triggers a multiply.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  a live instruction is in EX.
- `alu_ctrl_i`  in  3  ALU control code of that instruction.
- `src1_i`  in  WIDTH  multiplicand.
- `src2_i`  in  WIDTH  multiplier.
- `flush_i`  in  1  kill the EX instruction; aborts any multiply in progress.
- `stall_o`  out  1  freeze IF/ID/EX; reset value 0.
- `busy_o`  out  1  state is BUSY; reset value 0.
- `done_o`  out  1  one-cycle pulse: `result_o` is valid; reset value 0.
- `result_o`  out  WIDTH  low WIDTH bits of the product; reset value 0.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE and clears the accumulator, operand registers, counter and result.
- Start condition = IDLE & `valid_i` & (`alu_ctrl_i`==`MUL_CODE`) & ~`flush_i`.
- IDLE
  - On start: latch mcand=`src1_i`, mplier=`src2_i`; acc=0; cnt=0; next state BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - If mplier[0]: acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches ITER-1 (ITER=WIDTH): next state DONE and `result_o` <= final acc.
- DONE:
  - `done_o`=1 and `stall_o`=0, so the pipeline advances this cycle.
  - Next state IDLE.
- Flush:
  - `flush_i` in BUSY goes to IDLE next cycle, with no `done_o` and `result_o` unchanged.
  - `flush_i` in DONE still goes to IDLE next cycle; `done_o` is still high in that cycle.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; overflow bits are discarded.
  - The low WIDTH bits are identical for two's-complement operands, so no sign handling is needed.
- Async reset mid-operation: immediately IDLE, all outputs 0, and the operation is lost.
- Non-MUL codes or `valid_i`=0: no state change, `stall_o`=0.

## Timing
- `stall_o` = (IDLE & start) | BUSY. It is combinational and goes high in the start cycle itself.
- Cycle 0: start accepted.
- Cycles 1..ITER: BUSY.
- Cycle ITER+1: DONE, with `done_o`=1 and `result_o` valid.
- Total stall is ITER+1 cycles: 33 for WIDTH=32.
- `result_o` is registered and holds its value until the next completed multiply.
- A new start cannot occur in DONE. The earliest back-to-back start is the cycle after DONE (IDLE), once the next instruction has entered EX.
- `busy_o` is a registered state decode.

## Configuration
- `ALU_MUL_RADIX4_EN` defined:
  - Each BUSY cycle consumes 2 multiplier bits: acc += mcand × mplier[1:0], where 3× is computed as mcand + (mcand<<1).
  - mcand <<= 2; mplier >>= 2; ITER = WIDTH/2 (16).
  - Total stall is 17 cycles.
- Undefined: radix-2 as described above, ITER = WIDTH.
- Results are identical in both modes; only latency differs.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - ALU control code constants: ADD 000, SUB 001, AND 010, OR 011, MUL 100.
  - The sequencer state enum (IDLE/BUSY/DONE).
  - The ITER constant, derived under `ALU_MUL_RADIX4_EN`.
- One combinational sub-module, `alu_mul_step`, computes one iteration: next acc, mcand and mplier. Radix selection lives inside it.
- FSM, counter and registers stay in `alu_mul_seq`.

## Test plan
- MUL 3×5 → `stall_o` high for cycles 0–32; `done_o` in cycle 33 with `result_o`=15 (radix-4: `done_o` in cycle 17).
- MUL 0xFFFFFFFF×0xFFFFFFFF → `result_o`=0x00000001. MUL 0x80000000×2 → `result_o`=0.
- `alu_ctrl_i`=000 with `valid_i`=1 → `stall_o`=0, `busy_o`=0, `result_o` unchanged.
- Start 7×9, `flush_i` in BUSY cycle 10 → IDLE in cycle 11, no `done_o`, `result_o` keeps its old value; a following 2×2 yields 4.
- Async `rst_i` low in BUSY cycle 5 → all outputs 0 immediately; after release, 6×7 yields 42 with full latency.
- Back-to-back MULs 4×4 then 5×5 → results 16 then 25; second start in the cycle after the first DONE; total 68 cycles (radix-2).
